// File: rtl/branch_update_queue_pkg.sv
// Shared fetch/branch types for the branch-update path: the per-lane execution
// result record and the sizing of the predictor update queue.
package branch_update_queue_pkg;

    localparam int unsigned BRQ_ISSUE_WIDTH = 2;
    localparam int unsigned BRQ_DEPTH       = 8;
    localparam int unsigned BRQ_ADDR_W      = 32;
    localparam int unsigned BRQ_PTR_W       = $clog2(BRQ_DEPTH);
    localparam int unsigned BRQ_CNT_W       = BRQ_PTR_W + 1;
    localparam int unsigned BRQ_MISP_W      = 16;

    typedef logic [BRQ_PTR_W-1:0] BrqPtr;
    typedef logic [BRQ_CNT_W-1:0] BrqCount;

    typedef struct packed {
        logic                  valid;
        logic [BRQ_ADDR_W-1:0] brAddr;
        logic [BRQ_ADDR_W-1:0] target;
        logic [BRQ_ADDR_W-1:0] apAddr;
        logic                  execTaken;
        logic                  isAX;
        logic                  mispred;
    } BranchResult;

endpackage

// File: rtl/branch_update_queue_if.sv
// Execution-stage result bus plus predictor update port of the branch update queue.
interface branch_update_queue_if
    import branch_update_queue_pkg::*;
#(
    parameter int unsigned INT_ISSUE_WIDTH = BRQ_ISSUE_WIDTH
) ();

    BranchResult [INT_ISSUE_WIDTH-1:0] brResultIn;
    logic                              clear;
    logic                              fullStall;
    logic                              updValid;
    logic                              updReady;
    BranchResult                       updResult;
    logic                              updBTB;
    logic                              updAXBTB;
    logic [BRQ_MISP_W-1:0]             mispredCount;

    modport master (
        output brResultIn, clear, updReady,
        input  fullStall, updValid, updResult, updBTB, updAXBTB, mispredCount
    );

    modport slave (
        input  brResultIn, clear, updReady,
        output fullStall, updValid, updResult, updBTB, updAXBTB, mispredCount
    );

endinterface

// File: rtl/branch_update_lane_compactor.sv
// Maps the lane valid mask to dense write offsets (prefix popcount) so valid
// lanes land in consecutive queue slots in ascending lane order.
module branch_update_lane_compactor #(
    parameter int unsigned LANES = 2,
    parameter int unsigned OFF_W = 2
) (
    input  logic [LANES-1:0]            i_valid_mask,
    output logic [LANES-1:0][OFF_W-1:0] o_offset,
    output logic [OFF_W-1:0]            o_num_valid
);

    logic [OFF_W-1:0] w_acc;

    always_comb begin
        w_acc    = '0;
        o_offset = '0;
        for (int i = 0; i < LANES; i++) begin
            o_offset[i] = w_acc;
            w_acc       = w_acc + OFF_W'(i_valid_mask[i]);
        end
        o_num_valid = w_acc;
    end

endmodule

// File: rtl/branch_update_queue.sv
// Multi-lane-in, single-out queue replaying execution branch results to the
// predictor update port, with back-pressure and a saturating mispredict counter.
module branch_update_queue
    import branch_update_queue_pkg::*;
#(
    parameter int unsigned INT_ISSUE_WIDTH = BRQ_ISSUE_WIDTH,
    parameter int unsigned DEPTH           = BRQ_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst,
    branch_update_queue_if.slave  bus
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned OFF_W = $clog2(INT_ISSUE_WIDTH + 1);

    BranchResult               r_mem [DEPTH];
    logic [PTR_W-1:0]          r_head;
    logic [PTR_W-1:0]          r_tail;
    logic [CNT_W-1:0]          r_count;
    logic [BRQ_MISP_W-1:0]     r_mispred_cnt;

    logic [INT_ISSUE_WIDTH-1:0]            w_valid_mask;
    logic [INT_ISSUE_WIDTH-1:0][OFF_W-1:0] w_offset;
    logic [OFF_W-1:0]                      w_num_valid;
    logic [INT_ISSUE_WIDTH-1:0]            w_lane_acc;
    logic [INT_ISSUE_WIDTH-1:0][PTR_W-1:0] w_wr_idx;
    logic [CNT_W-1:0]                      w_free;
    logic [CNT_W-1:0]                      w_num_acc;
    logic                                  w_upd_valid;
    logic                                  w_deq;
    BranchResult                           w_head;

    always_comb begin
        w_valid_mask = '0;
        for (int i = 0; i < INT_ISSUE_WIDTH; i++) begin
            w_valid_mask[i] = bus.brResultIn[i].valid;
        end
    end

    branch_update_lane_compactor #(
        .LANES (INT_ISSUE_WIDTH),
        .OFF_W (OFF_W)
    ) u_compactor (
        .i_valid_mask (w_valid_mask),
        .o_offset     (w_offset),
        .o_num_valid  (w_num_valid)
    );

    assign w_free = CNT_W'(DEPTH) - r_count;

    // Lanes whose compacted slot exceeds the free space are dropped (top lanes first).
    always_comb begin
        w_lane_acc = '0;
        w_wr_idx   = '0;
        w_num_acc  = '0;
        for (int i = 0; i < INT_ISSUE_WIDTH; i++) begin
            w_lane_acc[i] = w_valid_mask[i] && !bus.clear && (CNT_W'(w_offset[i]) < w_free);
            w_wr_idx[i]   = r_tail + PTR_W'(w_offset[i]);
            w_num_acc     = w_num_acc + CNT_W'(w_lane_acc[i]);
        end
    end

    assign w_upd_valid = (r_count != '0);
    assign w_head      = r_mem[r_head];
    assign w_deq       = w_upd_valid && bus.updReady;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (bus.clear) begin
            r_head  <= r_tail;
            r_count <= '0;
        end else begin
            r_tail  <= r_tail + PTR_W'(w_num_acc);
            r_head  <= r_head + PTR_W'(w_deq);
            r_count <= r_count + w_num_acc - CNT_W'(w_deq);
        end
    end

    // Storage holds data only; occupancy is tracked entirely by r_count.
    always_ff @(posedge clk) begin
        for (int i = 0; i < INT_ISSUE_WIDTH; i++) begin
            if (w_lane_acc[i]) begin
                r_mem[w_wr_idx[i]] <= bus.brResultIn[i];
            end
        end
    end

    // A dequeue in a clearing cycle still reaches the predictor, so it is counted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mispred_cnt <= '0;
        end else if (w_deq && w_head.mispred && (r_mispred_cnt != '1)) begin
            r_mispred_cnt <= r_mispred_cnt + BRQ_MISP_W'(1);
        end
    end

    assign bus.updValid     = w_upd_valid;
    assign bus.updResult    = w_head;
    assign bus.updBTB       = w_upd_valid && w_head.execTaken && !w_head.isAX;
    assign bus.updAXBTB     = w_upd_valid && w_head.isAX;
    assign bus.fullStall    = (w_free < CNT_W'(INT_ISSUE_WIDTH));
    assign bus.mispredCount = r_mispred_cnt;

    a_no_lane_drop: assert property (@(posedge clk) disable iff (rst)
        bus.clear || (CNT_W'(w_num_valid) <= w_free))
        else $error("branch_update_queue: valid lanes dropped for lack of space");

endmodule

// File: tb/tb_branch_update_queue.sv
// Self-checking bench for branch_update_queue: vector table plus hand sequences,
// with a reference queue scoreboard for every entry presented to the predictor.
module tb_branch_update_queue;
    import branch_update_queue_pkg::*;

    logic clk = 1'b0;
    logic rst;

    branch_update_queue_if #(.INT_ISSUE_WIDTH(2)) bus ();

    branch_update_queue #(.INT_ISSUE_WIDTH(2), .DEPTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        BranchResult l0;
        BranchResult l1;
        logic        rdy;
        int unsigned cnt;
        logic        vld;
        logic        stl;
    } vec_t;

    vec_t          vecs [16];
    BranchResult   sb [$];
    BranchResult   NONE;
    logic [15:0]   exp_mis;
    int            total;
    int            bad;

    function automatic BranchResult mk(input logic v, input logic [31:0] br, input logic [31:0] ap,
                                       input logic tk, input logic ax, input logic mp);
        BranchResult r;
        r.valid     = v;
        r.brAddr    = br;
        r.target    = br + 32'h40;
        r.apAddr    = ap;
        r.execTaken = tk;
        r.isAX      = ax;
        r.mispred   = mp;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // One clock: drive at negedge, check against the model, then let the edge happen.
    task automatic cycle(input BranchResult l0, input BranchResult l1, input logic rdy, input logic clr);
        BranchResult h;
        bus.brResultIn[0] = l0;
        bus.brResultIn[1] = l1;
        bus.updReady      = rdy;
        bus.clear         = clr;
        #1;
        chk("upd_valid", 128'(bus.updValid), 128'(sb.size() != 0));
        chk("full_stall", 128'(bus.fullStall), 128'((8 - sb.size()) < 2));
        chk("mispred_count", 128'(bus.mispredCount), 128'(exp_mis));
        if (sb.size() != 0) begin
            h = sb[0];
            chk("upd_result", 128'(bus.updResult), 128'(h));
            chk("upd_btb", 128'(bus.updBTB), 128'(h.execTaken && !h.isAX));
            chk("upd_axbtb", 128'(bus.updAXBTB), 128'(h.isAX));
            if (rdy) begin
                void'(sb.pop_front());
                if (h.mispred && exp_mis != 16'hFFFF) exp_mis = exp_mis + 16'd1;
            end
        end else begin
            chk("idle_btb", 128'({bus.updBTB, bus.updAXBTB}), 128'(0));
        end
        if (clr) begin
            sb.delete();
        end else begin
            if (l0.valid) sb.push_back(l0);
            if (l1.valid) sb.push_back(l1);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        exp_mis = 16'd0;
        NONE    = '0;
        bus.brResultIn = '0;
        bus.updReady   = 1'b0;
        bus.clear      = 1'b0;

        vecs[0] = '{mk(1, 32'h100, 32'h0, 1, 0, 0), NONE, 1'b1, 1, 1'b1, 1'b0};
        vecs[1] = '{NONE, NONE, 1'b1, 0, 1'b0, 1'b0};
        vecs[2] = '{NONE, mk(1, 32'h40, 32'h240, 0, 1, 0), 1'b0, 1, 1'b1, 1'b0};
        vecs[3] = '{NONE, NONE, 1'b1, 0, 1'b0, 1'b0};
        for (int k = 0; k < 4; k++) begin
            vecs[4+k] = '{mk(1, 32'h2000 + 32'(k*16), 32'h0, k[0], 0, 0),
                          mk(1, 32'h2008 + 32'(k*16), 32'h3000, 1, k[1], 0),
                          1'b0, 32'(2*(k+1)), 1'b1, (k == 3)};
        end
        for (int j = 0; j < 8; j++) begin
            vecs[8+j] = '{NONE, NONE, 1'b1, 32'(7-j), (j != 7), (j == 0)};
        end

        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_valid", 128'(bus.updValid), 128'(0));
        chk("reset_stall", 128'(bus.fullStall), 128'(0));
        chk("reset_mispred", 128'(bus.mispredCount), 128'(0));
        chk("reset_btb", 128'({bus.updBTB, bus.updAXBTB}), 128'(0));
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 16; i++) begin
            cycle(vecs[i].l0, vecs[i].l1, vecs[i].rdy, 1'b0);
            chk("vec_count", 128'(dut.r_count), 128'(vecs[i].cnt));
            chk("vec_valid", 128'(bus.updValid), 128'(vecs[i].vld));
            chk("vec_stall", 128'(bus.fullStall), 128'(vecs[i].stl));
        end

        // Wrap-around: realign pointers to 0 via reset, fill/drain 7, then a two-lane write.
        rst = 1'b1;
        #2;
        rst = 1'b0;
        sb.delete();
        @(negedge clk);
        for (int k = 0; k < 3; k++)
            cycle(mk(1, 32'h4000 + 32'(k*16), 0, 1, 0, 0), mk(1, 32'h4008 + 32'(k*16), 0, 0, 0, 0), 1'b0, 1'b0);
        cycle(mk(1, 32'h4100, 0, 1, 0, 0), NONE, 1'b0, 1'b0);
        chk("wrap_fill_count", 128'(dut.r_count), 128'(7));
        repeat (7) cycle(NONE, NONE, 1'b1, 1'b0);
        chk("wrap_tail", 128'(dut.r_tail), 128'(7));
        cycle(mk(1, 32'h5000, 0, 1, 0, 0), mk(1, 32'h5004, 32'h5100, 0, 1, 0), 1'b0, 1'b0);
        chk("wrap_mem7", 128'(dut.r_mem[7].brAddr), 128'(32'h5000));
        chk("wrap_mem0", 128'(dut.r_mem[0].brAddr), 128'(32'h5004));
        chk("wrap_tail_after", 128'(dut.r_tail), 128'(1));
        repeat (3) cycle(NONE, NONE, 1'b1, 1'b0);

        // Simultaneous enqueue/dequeue at count 7, then clear with incoming lanes.
        for (int k = 0; k < 3; k++)
            cycle(mk(1, 32'h6000 + 32'(k*16), 0, 0, 0, 0), mk(1, 32'h6008 + 32'(k*16), 0, 1, 0, 0), 1'b0, 1'b0);
        cycle(mk(1, 32'h6100, 0, 1, 0, 0), NONE, 1'b0, 1'b0);
        cycle(mk(1, 32'h6200, 0, 0, 0, 0), NONE, 1'b1, 1'b0);
        chk("simul_count", 128'(dut.r_count), 128'(7));
        cycle(mk(1, 32'h6300, 0, 1, 0, 0), mk(1, 32'h6304, 0, 1, 0, 0), 1'b1, 1'b1);
        chk("clear_count", 128'(dut.r_count), 128'(0));
        chk("clear_valid", 128'(bus.updValid), 128'(0));
        chk("clear_ptrs", 128'(dut.r_head), 128'(dut.r_tail));
        cycle(NONE, NONE, 1'b1, 1'b0);

        // Mispredict counting: three mispredicted, two correct.
        cycle(mk(1, 32'h7000, 0, 1, 0, 1), mk(1, 32'h7004, 0, 1, 0, 1), 1'b0, 1'b0);
        cycle(mk(1, 32'h7010, 0, 0, 0, 1), mk(1, 32'h7014, 0, 0, 0, 0), 1'b0, 1'b0);
        cycle(mk(1, 32'h7020, 0, 1, 1, 0), NONE, 1'b0, 1'b0);
        repeat (6) cycle(NONE, NONE, 1'b1, 1'b0);
        chk("mispred_three", 128'(bus.mispredCount), 128'(16'd3));

        // Asynchronous reset pulse between clock edges with a non-empty queue.
        cycle(mk(1, 32'h7100, 0, 1, 0, 0), mk(1, 32'h7104, 0, 1, 0, 0), 1'b0, 1'b0);
        bus.brResultIn = '0;
        bus.updReady   = 1'b0;
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("async_valid", 128'(bus.updValid), 128'(0));
        chk("async_mispred", 128'(bus.mispredCount), 128'(0));
        chk("async_stall", 128'(bus.fullStall), 128'(0));
        chk("async_btb", 128'({bus.updBTB, bus.updAXBTB}), 128'(0));
        rst = 1'b0;
        sb.delete();
        exp_mis = 16'd0;
        @(negedge clk);

        // Saturation: 65536 mispredicted dequeues, one past the ceiling.
        for (int i = 0; i < 65537; i++)
            cycle(mk(1, 32'(i) << 2, 0, i[0], 0, 1), NONE, 1'b1, 1'b0);
        chk("mispred_sat", 128'(bus.mispredCount), 128'(16'hFFFF));
        cycle(NONE, NONE, 1'b1, 1'b0);
        chk("mispred_sat_hold", 128'(bus.mispredCount), 128'(16'hFFFF));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
